// File: rtl/tdm_mux8_if.sv
// tdm_mux8_if -- channel/line bundle for the 8-channel TDM transmitter.
//
// The master drives the run request and the parallel channel data/mask.
// The slave (tdm_mux8) returns the serialized line, the far-end demux select,
// the slot qualifiers and the completed-frame count.
//
//   en        master->slave  run request
//   in[7:0]   master->slave  parallel channel data, bit k = channel k
//   mask[7:0] master->slave  channel mask, bit k = 1 forces slot k to 0
//   out       slave->master  serialized slot data
//   sel[2:0]  slave->master  channel index of the current slot
//   valid     slave->master  out/sel carry a slot
//   sync      slave->master  slot 0 of a frame
//   busy      slave->master  transmitter is shifting a frame
//   frame_cnt slave->master  completed-frame counter, wraps silently
interface tdm_mux8_if #(
  parameter int FCNT_W = 8
) ();
  logic              en;
  logic [7:0]        in;
  logic [7:0]        mask;
  logic              out;
  logic [2:0]        sel;
  logic              valid;
  logic              sync;
  logic              busy;
  logic [FCNT_W-1:0] frame_cnt;

  modport master (
    output en, in, mask,
    input  out, sel, valid, sync, busy, frame_cnt
  );

  modport slave (
    input  en, in, mask,
    output out, sel, valid, sync, busy, frame_cnt
  );
endinterface

// File: rtl/tdm_mux8.sv
// tdm_mux8 -- transmit end of a 1-to-8 time-division multiplexed channel path.
//
// A frame is 8 consecutive slots; slot k carries channel k of the data word
// captured when the frame started (masked channels read as 0). Frames run
// back-to-back while en stays high; dropping en never truncates a frame.
//
// Ports:
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    tdm_mux8_if.slave (en/in/mask in; out/sel/valid/sync/busy/frame_cnt out)
//
// Every output is a flop. The output flops are loaded from the *next* state,
// so they always describe the current state/slot: the edge that samples
// en=1 in IDLE is followed directly by slot 0 on the outputs.
module tdm_mux8 #(
  parameter int FCNT_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  tdm_mux8_if.slave     bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Current state
  state_t            state_q;
  logic [2:0]        slot_q;
  logic [7:0]        d_q;       // data shadow, captured at frame start
  logic [7:0]        m_q;       // mask shadow, captured at frame start
  logic [FCNT_W-1:0] cnt_q;

  // Registered outputs
  logic              out_q;
  logic [2:0]        sel_q;
  logic              valid_q;
  logic              sync_q;
  logic              busy_q;

  // Next-state values
  state_t            state_nxt;
  logic [2:0]        slot_nxt;
  logic [7:0]        d_nxt;
  logic [7:0]        m_nxt;
  logic [FCNT_W-1:0] cnt_nxt;
  logic              out_nxt;
  logic [2:0]        sel_nxt;
  logic              valid_nxt;
  logic              sync_nxt;
  logic              busy_nxt;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; a missing default here would infer a latch.
    state_nxt = state_q;
    slot_nxt  = slot_q;
    d_nxt     = d_q;
    m_nxt     = m_q;
    cnt_nxt   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.en) begin
          d_nxt     = bus.in;
          m_nxt     = bus.mask;
          slot_nxt  = 3'd0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (slot_q != 3'd7) begin
          // Mid-frame: en is ignored so a frame always completes.
          slot_nxt = slot_q + 3'd1;
        end else begin
          cnt_nxt  = cnt_q + 1'b1;   // wraps silently
          slot_nxt = 3'd0;
          if (bus.en) begin
            // Back-to-back frame: re-capture with no gap slot.
            d_nxt = bus.in;
            m_nxt = bus.mask;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Output decode of the next state, so the flops mirror the state.
    out_nxt   = 1'b0;
    sel_nxt   = 3'd0;
    valid_nxt = 1'b0;
    sync_nxt  = 1'b0;
    busy_nxt  = 1'b0;
    if (state_nxt == SHIFT) begin
      out_nxt   = d_nxt[slot_nxt] & ~m_nxt[slot_nxt];
      sel_nxt   = slot_nxt;
      valid_nxt = 1'b1;
      sync_nxt  = (slot_nxt == 3'd0);
      busy_nxt  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the D/M shadows are reset too: a frame aborted by reset must
      // leave no stale channel data behind, and they are only 16 flops.
      state_q <= IDLE;
      slot_q  <= 3'd0;
      d_q     <= 8'd0;
      m_q     <= 8'd0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      sel_q   <= 3'd0;
      valid_q <= 1'b0;
      sync_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      slot_q  <= slot_nxt;
      d_q     <= d_nxt;
      m_q     <= m_nxt;
      cnt_q   <= cnt_nxt;
      out_q   <= out_nxt;
      sel_q   <= sel_nxt;
      valid_q <= valid_nxt;
      sync_q  <= sync_nxt;
      busy_q  <= busy_nxt;
    end
  end

  assign bus.out       = out_q;
  assign bus.sel       = sel_q;
  assign bus.valid     = valid_q;
  assign bus.sync      = sync_q;
  assign bus.busy      = busy_q;
  assign bus.frame_cnt = cnt_q;

endmodule

// File: tb/tb_tdm_mux8.sv
// tb_tdm_mux8 -- self-checking bench for tdm_mux8.
// A table of {inputs, expected outputs} rows covers single, masked and
// early-drop frames; hand-written sequences cover continuous frames,
// asynchronous reset mid-frame and counter wrap (second instance, FCNT_W=2).
module tb_tdm_mux8;

  logic clk;
  logic rst_n;

  tdm_mux8_if #(.FCNT_W(8)) bus  ();
  tdm_mux8_if #(.FCNT_W(2)) bus2 ();

  tdm_mux8 #(.FCNT_W(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  tdm_mux8 #(.FCNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply inputs before the edge, then settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       en;
    logic [7:0] din;
    logic [7:0] mask;
    logic       out;
    logic [2:0] sel;
    logic       valid;
    logic       sync;
    logic       busy;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, input logic [7:0] din, input logic [7:0] mask,
                     input logic out, input logic [2:0] sel, input logic valid,
                     input logic sync, input logic busy, input logic [7:0] cnt);
    vec_t v;
    v.en = en; v.din = din; v.mask = mask;
    v.out = out; v.sel = sel; v.valid = valid; v.sync = sync; v.busy = busy; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  function automatic logic [6:0] pack_out(input logic o, input logic [2:0] s,
                                          input logic v, input logic sy, input logic b);
    return {o, s, v, sy, b};
  endfunction

  initial begin
    logic [7:0] frames [3];
    logic [1:0] wrap_exp [5];
    int         valid_cycles;

    // ---------------- vector table ----------------
    // Single frame 8'hA5, en high for one edge; in changes afterwards are ignored.
    //  en  in     mask   out sel v sy b cnt
    add(1, 8'hA5, 8'h00, 1, 0, 1, 1, 1, 0);
    add(0, 8'h00, 8'h00, 0, 1, 1, 0, 1, 0);
    add(0, 8'h00, 8'h00, 1, 2, 1, 0, 1, 0);
    add(0, 8'h00, 8'h00, 0, 3, 1, 0, 1, 0);
    add(0, 8'h00, 8'h00, 0, 4, 1, 0, 1, 0);
    add(0, 8'h00, 8'h00, 1, 5, 1, 0, 1, 0);
    add(0, 8'h00, 8'h00, 0, 6, 1, 0, 1, 0);
    add(0, 8'h00, 8'h00, 1, 7, 1, 0, 1, 0);
    add(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1);
    add(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1);
    // Masked frame: FF with mask 0F; mask/in changes after capture are ignored.
    add(1, 8'hFF, 8'h0F, 0, 0, 1, 1, 1, 1);
    add(0, 8'h00, 8'hFF, 0, 1, 1, 0, 1, 1);
    add(0, 8'h00, 8'hFF, 0, 2, 1, 0, 1, 1);
    add(0, 8'h00, 8'hFF, 0, 3, 1, 0, 1, 1);
    add(0, 8'h00, 8'hFF, 1, 4, 1, 0, 1, 1);
    add(0, 8'h00, 8'hFF, 1, 5, 1, 0, 1, 1);
    add(0, 8'h00, 8'hFF, 1, 6, 1, 0, 1, 1);
    add(0, 8'h00, 8'hFF, 1, 7, 1, 0, 1, 1);
    add(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 2);
    // Early drop: 8'h3C, en held through slot 1, low from slot 2 on.
    add(1, 8'h3C, 8'h00, 0, 0, 1, 1, 1, 2);
    add(1, 8'h3C, 8'h00, 0, 1, 1, 0, 1, 2);
    add(0, 8'h3C, 8'h00, 1, 2, 1, 0, 1, 2);
    add(0, 8'h3C, 8'h00, 1, 3, 1, 0, 1, 2);
    add(0, 8'h3C, 8'h00, 1, 4, 1, 0, 1, 2);
    add(0, 8'h3C, 8'h00, 1, 5, 1, 0, 1, 2);
    add(0, 8'h3C, 8'h00, 0, 6, 1, 0, 1, 2);
    add(0, 8'h3C, 8'h00, 0, 7, 1, 0, 1, 2);
    add(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 3);
    add(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 3);

    // ---------------- reset ----------------
    rst_n = 1'b0;
    bus.en = 1'b0;  bus.in = 8'h00;  bus.mask = 8'h00;
    bus2.en = 1'b0; bus2.in = 8'h00; bus2.mask = 8'h00;
    #1;
    check("reset outputs", 32'(pack_out(bus.out, bus.sel, bus.valid, bus.sync, bus.busy)), 32'd0);
    check("reset frame_cnt", 32'(bus.frame_cnt), 32'd0);
    tick();
    #2 rst_n = 1'b1;
    // First edge after reset with en=0 must not start a frame.
    tick();
    check("post-reset idle valid", 32'(bus.valid), 32'd0);

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      bus.en   = vecs[i].en;
      bus.in   = vecs[i].din;
      bus.mask = vecs[i].mask;
      tick();
      check($sformatf("vec%0d out/sel/valid/sync/busy", i),
            32'(pack_out(bus.out, bus.sel, bus.valid, bus.sync, bus.busy)),
            32'(pack_out(vecs[i].out, vecs[i].sel, vecs[i].valid, vecs[i].sync, vecs[i].busy)));
      check($sformatf("vec%0d frame_cnt", i), 32'(bus.frame_cnt), 32'(vecs[i].cnt));
    end

    // ---------------- continuous: 3 back-to-back frames ----------------
    frames[0] = 8'h96; frames[1] = 8'h5A; frames[2] = 8'hC3;
    valid_cycles = 0;
    bus.en = 1'b1;
    bus.mask = 8'h00;
    for (int f = 0; f < 3; f++) begin
      for (int s = 0; s < 8; s++) begin
        if (s == 0) bus.in = frames[f];
        if (s == 4) bus.in = ~frames[f];         // mid-frame change, must be ignored
        if (f == 2 && s == 1) bus.en = 1'b0;     // let the third frame be the last
        tick();
        if (bus.valid === 1'b1) valid_cycles++;
        check($sformatf("cont f%0d s%0d out", f, s), 32'(bus.out), 32'(frames[f][s]));
        check($sformatf("cont f%0d s%0d sel", f, s), 32'(bus.sel), 32'(s));
        check($sformatf("cont f%0d s%0d sync", f, s), 32'(bus.sync), 32'(s == 0));
        if (s == 0)
          check($sformatf("cont f%0d frame_cnt", f), 32'(bus.frame_cnt), 32'(3 + f));
      end
    end
    check("cont valid cycles", 32'(valid_cycles), 32'd24);
    tick();
    check("cont end valid", 32'(bus.valid), 32'd0);
    check("cont end frame_cnt", 32'(bus.frame_cnt), 32'd6);

    // ---------------- asynchronous reset mid-frame ----------------
    bus.en = 1'b1; bus.in = 8'hFF; bus.mask = 8'h00;
    tick();                       // slot 0
    bus.en = 1'b0;
    repeat (4) tick();            // slot 4
    check("pre-reset sel", 32'(bus.sel), 32'd4);
    #2 rst_n = 1'b0;
    #1;                           // still well before the next edge
    check("mid-frame reset outputs",
          32'(pack_out(bus.out, bus.sel, bus.valid, bus.sync, bus.busy)), 32'd0);
    check("mid-frame reset frame_cnt", 32'(bus.frame_cnt), 32'd0);
    tick();
    #2 rst_n = 1'b1;
    repeat (3) tick();
    check("after reset idle busy", 32'(bus.busy), 32'd0);
    check("after reset frame_cnt", 32'(bus.frame_cnt), 32'd0);
    bus.en = 1'b1; bus.in = 8'h02; bus.mask = 8'h00;
    tick();
    check("restart slot0", 32'(pack_out(bus.out, bus.sel, bus.valid, bus.sync, bus.busy)),
          32'(pack_out(1'b0, 3'd0, 1'b1, 1'b1, 1'b1)));
    bus.en = 1'b0;
    tick();
    check("restart slot1 out", 32'(bus.out), 32'd1);

    // ---------------- frame_cnt wrap, FCNT_W=2 ----------------
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;
    bus2.en = 1'b1; bus2.in = 8'h01; bus2.mask = 8'h00;
    tick();
    check("wrap start frame_cnt", 32'(bus2.frame_cnt), 32'd0);
    for (int f = 0; f < 5; f++) begin
      repeat (8) tick();
      check($sformatf("wrap frame %0d frame_cnt", f + 1), 32'(bus2.frame_cnt), 32'(wrap_exp[f]));
    end
    bus2.en = 1'b0;
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tdm_mux8.md
TDM_MUX8 -- requirements
Module: tdm_mux8

Interface
REQ-001 Parameter FCNT_W, default 8, width of the completed-frame counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  run request; sampled on every rising edge.
REQ-005 in  input  8  parallel channel data; bit k belongs to channel k.
REQ-006 mask  input  8  channel mask; bit k = 1 forces channel k slot to 0.
REQ-007 out  output  1  serialized slot data, registered.
REQ-008 sel  output  3  channel index of the current slot, registered.
REQ-009 valid  output  1  high while out/sel carry a slot, registered.
REQ-010 sync  output  1  high during slot 0 of every frame, registered.
REQ-011 busy  output  1  high while state is SHIFT, registered.
REQ-012 frame_cnt  output  FCNT_W  count of completed frames, registered.

Function
REQ-013 Block is the transmit end of the 1-to-8 channel path: it time-division multiplexes 8 channels onto one line, and sel drives the far-end demux select.
REQ-014 Two states: IDLE, SHIFT, plus a 3-bit slot counter slot.
REQ-015 IDLE with en=1 at an edge: capture in into shadow register D and mask into shadow register M; go to SHIFT with slot=0.
REQ-016 IDLE with en=0: remain in IDLE; D and M hold their values.
REQ-017 SHIFT with slot<7: slot increments by 1 each edge, regardless of en.
REQ-018 SHIFT with slot=7 and en=1: re-capture D and M from in and mask, set slot=0, increment frame_cnt, and stay in SHIFT, giving back-to-back 8-cycle frames with no gap.
REQ-019 SHIFT with slot=7 and en=0: increment frame_cnt and go to IDLE.
REQ-020 Deassertion of en mid-frame never truncates a frame; the frame in progress always completes all 8 slots.
REQ-021 Changes on in or mask after capture do not affect the frame in progress.
REQ-022 In SHIFT: out = D[slot] AND NOT M[slot]; sel = slot; valid = 1; sync = (slot==0); busy = 1.
REQ-023 In IDLE: out = 0, sel = 0, valid = 0, sync = 0, busy = 0.
REQ-024 Latency: the edge that samples en=1 in IDLE is followed by slot 0 on the outputs, one cycle later.
REQ-025 frame_cnt wraps from 2^FCNT_W-1 to 0 without error indication.
REQ-026 frame_cnt increments exactly once per completed frame, at the slot-7 edge.
REQ-027 All outputs are driven from flops; no combinational path exists from inputs to outputs.

Reset
REQ-028 rst_n=0 asynchronously forces state=IDLE, slot=0, D=0, M=0, frame_cnt=0, out=0, sel=0, valid=0, sync=0, busy=0.
REQ-029 Reset asserted mid-frame abandons the frame; frame_cnt does not count it.
REQ-030 After rst_n deasserts, the first possible frame start is the first edge with en=1.

Verification
REQ-031 Single frame: in=8'hA5, mask=0, en high for one edge then low -> over 8 cycles out=1,0,1,0,0,1,0,1 with sel=0..7; sync only with sel=0; then IDLE; frame_cnt=1.
REQ-032 Masking: in=8'hFF, mask=8'h0F -> out=0 for slots 0-3 and 1 for slots 4-7; valid=1 in all 8 slots.
REQ-033 Continuous: en held high for 3 frames with in changed mid-frame -> 24 contiguous valid cycles; each frame carries the value captured at its start; frame_cnt=3.
REQ-034 Early drop: en low at slot 2 -> frame completes through sel=7, then valid=0.
REQ-035 Reset mid-frame: rst_n low at slot 4 -> all outputs 0 immediately, before the next clock edge; frame_cnt=0.
REQ-036 Wrap: FCNT_W=2, 5 frames -> frame_cnt reads 1,2,3,0,1.
